// File: rtl/store_buffer_pkg.sv
// Shared constants, entry layout and drain-state encoding for the store buffer.
`default_nettype none

package store_buffer_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int FUNCT3_WIDTH = 3;
  localparam int WADDR_W      = CPU_WIDTH - 2;
  localparam int ENTRY_W      = WADDR_W + CPU_WIDTH + 4;

  localparam logic [FUNCT3_WIDTH-1:0] INST_SB = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] INST_SH = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] INST_SW = 3'b010;

  typedef enum logic [0:0] {
    STB_IDLE = 1'b0,
    STB_REQ  = 1'b1
  } stb_state_e;

  typedef struct packed {
    logic [WADDR_W-1:0]   waddr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [3:0]           wstrb;
  } stb_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_fifo.sv
// Synchronous FIFO holding formatted stores; exposes every slot and its valid bit.
`default_nettype none

module store_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              din_i,
  output logic [WIDTH-1:0]              head_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][WIDTH-1:0]   entries_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;

  // Callers never push when full or pop when empty, so no guarding here.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) begin
      mem_d[wr_ptr_q] = din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr_q;
    assign valid_o[i] = ({1'b0, off} < count_q);
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// Memory-stage store path: formats SB/SH/SW, queues them and drains to memory over req/ack.
`default_nettype none

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [CPU_WIDTH-1:0]    st_addr_i,
  input  logic [CPU_WIDTH-1:0]    st_data_i,
  input  logic [FUNCT3_WIDTH-1:0] funct3_i,
  output logic                    misalign_o,
  input  logic [CPU_WIDTH-1:0]    ld_addr_i,
  output logic                    ld_hit_o,
  output logic                    mem_req_o,
  output logic [CPU_WIDTH-1:0]    mem_addr_o,
  output logic [CPU_WIDTH-1:0]    mem_wdata_o,
  output logic [3:0]              mem_wstrb_o,
  input  logic                    mem_ack_i,
  output logic                    empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]           k;
  logic                 fmt_ok;
  logic                 misaligned;
  logic [CPU_WIDTH-1:0] fmt_wdata;
  logic [3:0]           fmt_wstrb;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 misalign_q, misalign_d;
  stb_state_e           state_q, state_d;
  stb_entry_t           new_entry;
  stb_entry_t           head;
  logic [ENTRY_W-1:0]   head_raw;
  logic [CW-1:0]        count;
  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     hit_vec;
  logic [DEPTH-1:0][ENTRY_W-1:0] entries;
  logic                 unused_ld_bits;

  assign k = st_addr_i[1:0];

  always_comb begin
    fmt_ok     = 1'b0;
    misaligned = 1'b0;
    fmt_wdata  = '0;
    fmt_wstrb  = '0;
    case (funct3_i)
      INST_SB: begin
        fmt_ok    = 1'b1;
        fmt_wdata = {4{st_data_i[7:0]}};
        fmt_wstrb = 4'b0001 << k;
      end
      INST_SH: begin
        fmt_ok     = ~k[0];
        misaligned = k[0];
        fmt_wdata  = {2{st_data_i[15:0]}};
        fmt_wstrb  = k[1] ? 4'b1100 : 4'b0011;
      end
      INST_SW: begin
        fmt_ok     = (k == 2'b00);
        misaligned = (k != 2'b00);
        fmt_wdata  = st_data_i;
        fmt_wstrb  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign st_ready_o = (count < CW'(DEPTH));
  assign accept     = st_valid_i & st_ready_o;
  assign push       = accept & fmt_ok;
  assign misalign_d = accept & misaligned;

  assign new_entry.waddr = st_addr_i[CPU_WIDTH-1:2];
  assign new_entry.wdata = fmt_wdata;
  assign new_entry.wstrb = fmt_wstrb;

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     (new_entry),
    .head_o    (head_raw),
    .count_o   (count),
    .valid_o   (valid),
    .entries_o (entries)
  );

  assign head = stb_entry_t'(head_raw);

  // Outputs are zeroed outside REQ so the bus is quiet when nothing is pending.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = (state_q == STB_REQ);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    pop         = 1'b0;
    case (state_q)
      STB_IDLE: begin
        if (count != '0) begin
          state_d = STB_REQ;
        end
      end
      STB_REQ: begin
        mem_addr_o  = {head.waddr, 2'b00};
        mem_wdata_o = head.wdata;
        mem_wstrb_o = head.wstrb;
        pop         = mem_ack_i;
        if (mem_ack_i && (count == CW'(1)) && !push) begin
          state_d = STB_IDLE;
        end
      end
      default: state_d = STB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STB_IDLE;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
  assign empty_o    = (count == '0);

  // The head being popped is still valid this cycle; the store being accepted is not yet.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    stb_entry_t e;
    logic       unused_lane_bits;
    assign e                = stb_entry_t'(entries[i]);
    assign hit_vec[i]       = valid[i] & (e.waddr == ld_addr_i[CPU_WIDTH-1:2]);
    assign unused_lane_bits = ^{e.wdata, e.wstrb};
  end

  assign ld_hit_o       = |hit_vec;
  assign unused_ld_bits = ^ld_addr_i[1:0];

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected writes queued at accept, checked at ack.
`default_nettype none

module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [2:0]  funct3_i;
  logic        misalign_o;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic        empty_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   wr_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   writes   = 0;
  int   cyc      = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid_i  (st_valid_i),
    .st_ready_o  (st_ready_o),
    .st_addr_i   (st_addr_i),
    .st_data_i   (st_data_i),
    .funct3_i    (funct3_i),
    .misalign_o  (misalign_o),
    .ld_addr_i   (ld_addr_i),
    .ld_hit_o    (ld_hit_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ack_i   (mem_ack_i),
    .empty_o     (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every completed write is matched against the oldest expected store.
  always @(negedge clk) begin
    if (rst_n && mem_req_o && mem_ack_i) begin
      writes++;
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h wdata=%h wstrb=%b", mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end else begin
        e_mon = exp_q.pop_front();
        if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {e_mon.a, e_mon.d, e_mon.s}) begin
          failures++;
          $display("FAIL write_data got addr=%h wdata=%h wstrb=%b expected addr=%h wdata=%h wstrb=%b",
                   mem_addr_o, mem_wdata_o, mem_wstrb_o, e_mon.a, e_mon.d, e_mon.s);
        end
      end
    end
  end

  task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input bit exp_push, input logic [31:0] ea, input logic [31:0] ew,
                          input logic [3:0] es);
    int n;
    exp_t x;
    @(posedge clk); #1;
    st_valid_i = 1'b1;
    funct3_i   = f;
    st_addr_i  = a;
    st_data_i  = d;
    n = 0;
    @(negedge clk);
    while (!st_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready_o) begin
      checks++;
      failures++;
      $display("FAIL store_accept_timeout addr=%h got ready=%b expected ready=1", a, st_ready_o);
      st_valid_i = 1'b0;
      return;
    end
    if (exp_push) begin
      x.a = ea; x.d = ew; x.s = es;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    st_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(empty_o && !mem_req_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !empty_o) begin
      failures++;
      $display("FAIL drain got pending=%0d empty=%b expected pending=0 empty=1", exp_q.size(), empty_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({st_ready_o, misalign_o, ld_hit_o, mem_req_o, empty_o} !== 5'b10001 ||
        mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_wstrb_o !== 4'h0) begin
      failures++;
      $display("FAIL reset_values got rdy/mis/hit/req/emp=%b addr=%h wdata=%h wstrb=%b expected 10001 0 0 0",
               {st_ready_o, misalign_o, ld_hit_o, mem_req_o, empty_o}, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({st_ready_o, mem_req_o, empty_o} !== 3'b101) begin
      failures++;
      $display("FAIL post_reset_idle got rdy/req/emp=%b expected 101", {st_ready_o, mem_req_o, empty_o});
    end
  endtask

  task automatic test_sb_lanes();
    mem_ack_i = 1'b0;
    do_store(3'b000, 32'h0000_0103, 32'h0000_00A5, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000);
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b0 || empty_o !== 1'b0) begin
      failures++;
      $display("FAIL sb_first_cycle got req=%b empty=%b expected req=0 empty=0", mem_req_o, empty_o);
    end
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hA5A5A5A5 || mem_wstrb_o !== 4'b1000) begin
      failures++;
      $display("FAIL sb_request got req=%b addr=%h wdata=%h wstrb=%b expected 1 00000100 a5a5a5a5 1000",
               mem_req_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_after_ack got req=%b empty=%b expected req=0 empty=1", mem_req_o, empty_o);
    end
  endtask

  task automatic test_sh_sw_lanes();
    mem_ack_i = 1'b1;
    do_store(3'b001, 32'h0000_0202, 32'h0000_1234, 1'b1, 32'h0000_0200, 32'h1234_1234, 4'b1100);
    do_store(3'b001, 32'h0000_0208, 32'hFFFF_BEEF, 1'b1, 32'h0000_0208, 32'hBEEF_BEEF, 4'b0011);
    do_store(3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111);
    do_store(3'b000, 32'h0000_0311, 32'h0000_0077, 1'b1, 32'h0000_0310, 32'h7777_7777, 4'b0010);
    wait_drain();
    mem_ack_i = 1'b0;
  endtask

  task automatic test_misalign();
    do_store(3'b010, 32'h0000_0301, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (misalign_o !== 1'b1 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL sw_misalign_pulse got mis=%b empty=%b expected mis=1 empty=1", misalign_o, empty_o);
    end
    @(negedge clk);
    checks++;
    if (misalign_o !== 1'b0) begin
      failures++;
      $display("FAIL sw_misalign_width got mis=%b expected 0", misalign_o);
    end
    do_store(3'b001, 32'h0000_0201, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (misalign_o !== 1'b1 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL sh_misalign_pulse got mis=%b empty=%b expected mis=1 empty=1", misalign_o, empty_o);
    end
    do_store(3'b011, 32'h0000_0400, 32'h3333_3333, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (misalign_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL bad_funct3 got mis=%b empty=%b expected mis=0 empty=1", misalign_o, empty_o);
    end
  endtask

  task automatic test_full_back_to_back();
    int w;
    mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(3'b010, 32'h500 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1,
               32'h500 + 32'(4 * i), 32'h1000 + 32'(i), 4'b1111);
    end
    @(negedge clk);
    checks++;
    if (st_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got ready=%b expected 0", st_ready_o);
    end
    fork
      do_store(3'b010, 32'h510, 32'h1004, 1'b1, 32'h510, 32'h1004, 4'b1111);
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (st_ready_o !== 1'b0 || exp_q.size() != 4 || mem_addr_o !== 32'h500) begin
          failures++;
          $display("FAIL full_hold got ready=%b pending=%0d addr=%h expected 0 4 00000500",
                   st_ready_o, exp_q.size(), mem_addr_o);
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b1;
      end
    join
    wait_drain();
    mem_ack_i = 1'b0;
    w = wr_cyc.size();
    checks++;
    if (w < 5 || (wr_cyc[w-1] - wr_cyc[w-5]) != 4) begin
      failures++;
      $display("FAIL back_to_back got span=%0d expected span=4", (w < 5) ? -1 : wr_cyc[w-1] - wr_cyc[w-5]);
    end
  endtask

  task automatic test_load_hit();
    exp_t x;
    mem_ack_i = 1'b0;
    @(posedge clk); #1;
    st_valid_i = 1'b1;
    funct3_i   = 3'b000;
    st_addr_i  = 32'h400;
    st_data_i  = 32'h11;
    ld_addr_i  = 32'h402;
    @(negedge clk);
    checks++;
    if (ld_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL hit_same_cycle_accept got hit=%b expected 0", ld_hit_o);
    end
    x.a = 32'h400; x.d = 32'h1111_1111; x.s = 4'b0001;
    exp_q.push_back(x);
    @(posedge clk); #1;
    st_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_hit_o !== 1'b1) begin
      failures++;
      $display("FAIL hit_same_word got hit=%b expected 1", ld_hit_o);
    end
    ld_addr_i = 32'h404;
    #1;
    checks++;
    if (ld_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL hit_next_word got hit=%b expected 0", ld_hit_o);
    end
    ld_addr_i = 32'h402;
    @(posedge clk); #1;
    mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ld_hit_o !== 1'b1 || mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL hit_during_pop got hit=%b req=%b expected 1 1", ld_hit_o, mem_req_o);
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_hit_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL hit_after_ack got hit=%b empty=%b expected 0 1", ld_hit_o, empty_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    int w0;
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_store(3'b000, 32'h600 + 32'(i), 32'h40 + 32'(i), 1'b1, 32'h600, 32'h0, 4'h0);
    end
    n = 0;
    @(negedge clk);
    while (!mem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_drain_req got req=%b expected 1", mem_req_o);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || empty_o !== 1'b1 || st_ready_o !== 1'b1 || mem_wstrb_o !== 4'h0) begin
      failures++;
      $display("FAIL async_reset got req=%b empty=%b ready=%b wstrb=%b expected 0 1 1 0000",
               mem_req_o, empty_o, st_ready_o, mem_wstrb_o);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = writes;
    mem_ack_i = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (writes != w0 || mem_req_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_quiet got writes=%0d req=%b empty=%b expected writes=%0d 0 1",
               writes, mem_req_o, empty_o, w0);
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    st_valid_i = 1'b0;
    st_addr_i  = '0;
    st_data_i  = '0;
    funct3_i   = '0;
    ld_addr_i  = '0;
    mem_ack_i  = 1'b0;
    test_reset();
    test_sb_lanes();
    test_sh_sw_lanes();
    test_misalign();
    test_full_back_to_back();
    test_load_hit();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
